// File: rtl/detect_monitor.sv
// detect_monitor: windowed detect counter with sticky threshold alarm,
// a held window report and a saturating total detect count.
module detect_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             detect,
  input  logic             clear,
  input  logic             report_ready,
  output logic             report_valid,
  output logic [CNT_W-1:0] report_data,
  output logic             alarm,
  output logic [CNT_W-1:0] total_count
);
  typedef enum logic [1:0] {S_IDLE, S_WINDOW, S_REPORT} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);
  localparam logic [7:0]       TMR_INIT = 8'(WINDOW - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d, win_inc;
  logic [7:0]       timer_q, timer_d;
  logic             report_valid_q, report_valid_d;
  logic [CNT_W-1:0] report_data_q, report_data_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] total_q, total_d;
  always_comb begin
    state_d        = state_q;
    win_cnt_d      = win_cnt_q;
    timer_d        = timer_q;
    report_valid_d = report_valid_q;
    report_data_d  = report_data_q;
    alarm_d        = alarm_q;
    total_d        = (detect && total_q != CNT_MAX) ? total_q + 1'b1 : total_q;
    win_inc        = (detect && win_cnt_q != CNT_MAX) ? win_cnt_q + 1'b1 : win_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (detect && THRESH == 1) begin
          state_d        = S_REPORT;
          win_cnt_d      = CNT_W'(1);
          report_valid_d = 1'b1;
          report_data_d  = CNT_W'(1);
          alarm_d        = 1'b1;
        end else if (detect) begin
          state_d   = S_WINDOW;
          win_cnt_d = CNT_W'(1);
          timer_d   = TMR_INIT;
        end
      end
      S_WINDOW: begin
        timer_d   = timer_q - 8'd1;
        win_cnt_d = win_inc;
        // threshold hit wins over expiry in the same sample
        if (win_inc == THR) begin
          state_d        = S_REPORT;
          report_valid_d = 1'b1;
          report_data_d  = THR;
          alarm_d        = 1'b1;
        end else if (timer_q == 8'd0) begin
          state_d        = S_REPORT;
          report_valid_d = 1'b1;
          report_data_d  = win_inc;
        end
      end
      S_REPORT: begin
        if (report_ready) begin
          state_d        = S_IDLE;
          report_valid_d = 1'b0;
          win_cnt_d      = '0;
          timer_d        = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d        = S_IDLE;
      win_cnt_d      = '0;
      timer_d        = '0;
      report_valid_d = 1'b0;
      report_data_d  = '0;
      alarm_d        = 1'b0;
      total_d        = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      win_cnt_q      <= '0;
      timer_q        <= '0;
      report_valid_q <= 1'b0;
      report_data_q  <= '0;
      alarm_q        <= 1'b0;
      total_q        <= '0;
    end else begin
      state_q        <= state_d;
      win_cnt_q      <= win_cnt_d;
      timer_q        <= timer_d;
      report_valid_q <= report_valid_d;
      report_data_q  <= report_data_d;
      alarm_q        <= alarm_d;
      total_q        <= total_d;
    end
  end
  assign report_valid = report_valid_q;
  assign report_data  = report_data_q;
  assign alarm        = alarm_q;
  assign total_count  = total_q;
endmodule

// File: tb/tb_detect_monitor.sv
// tb_detect_monitor: scenario tasks plus a report scoreboard for detect_monitor.
module tb_detect_monitor;
  logic       clk = 1'b0, reset = 1'b0, detect = 1'b0, clear = 1'b0, report_ready = 1'b1;
  logic       report_valid, alarm;
  logic [7:0] report_data, total_count;
  logic [7:0] exp_q[$];
  logic [7:0] sb_e;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  detect_monitor #(.CNT_W(8), .WINDOW(16), .THRESH(3)) dut (
    .clk(clk), .reset(reset), .detect(detect), .clear(clear),
    .report_ready(report_ready), .report_valid(report_valid),
    .report_data(report_data), .alarm(alarm), .total_count(total_count)
  );
  // scoreboard consumer: every accepted report must match the oldest expectation
  always @(negedge clk) begin
    if (reset && report_valid && report_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got report data=%0d, required no report", report_data);
      end else begin
        sb_e = exp_q.pop_front();
        if (report_data !== sb_e) begin
          bad++;
          $display("FAIL sb_data: got %0d, required %0d", report_data, sb_e);
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse();
    detect = 1'b1;
    cyc();
    detect = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      detect = ~detect;
      cyc();
      total++;
      if ({report_valid, alarm, report_data, total_count} !== 18'd0) begin
        bad++;
        $display("FAIL reset_outputs: got %h, required 0", {report_valid, alarm, report_data, total_count});
      end
    end
    reset = 1'b1;
    detect = 1'b0;
    cyc();
    total++;
    if ({report_valid, alarm, report_data, total_count} !== 18'd0) begin
      bad++;
      $display("FAIL reset_first_idle: got %h, required 0", {report_valid, alarm, report_data, total_count});
    end
  endtask
  task automatic test_single();
    int n = 0;
    exp_q.push_back(8'd1);
    pulse();
    while (!report_valid && n < 30) begin cyc(); n++; end
    total++;
    if (n !== 16) begin bad++; $display("FAIL single_latency: got %0d, required 16", n); end
    total++;
    if (report_data !== 8'd1 || alarm !== 1'b0 || total_count !== 8'd1) begin
      bad++;
      $display("FAIL single_values: got data=%0d alarm=%0d total=%0d, required 1 0 1", report_data, alarm, total_count);
    end
    cyc();
    total++;
    if (report_valid !== 1'b0) begin bad++; $display("FAIL single_one_cycle: got %0d, required 0", report_valid); end
  endtask
  task automatic test_thresh();
    exp_q.push_back(8'd3);
    pulse();
    cyc();
    pulse();
    cyc();
    total++;
    if (alarm !== 1'b0 || report_valid !== 1'b0) begin
      bad++;
      $display("FAIL thresh_early: got alarm=%0d valid=%0d, required 0 0", alarm, report_valid);
    end
    pulse();
    total++;
    if (alarm !== 1'b1 || report_valid !== 1'b1 || report_data !== 8'd3 || total_count !== 8'd4) begin
      bad++;
      $display("FAIL thresh_hit: got alarm=%0d valid=%0d data=%0d total=%0d, required 1 1 3 4", alarm, report_valid, report_data, total_count);
    end
    cyc();
    total++;
    if (report_valid !== 1'b0 || alarm !== 1'b1) begin
      bad++;
      $display("FAIL thresh_after: got valid=%0d alarm=%0d, required 0 1", report_valid, alarm);
    end
  endtask
  task automatic test_backpressure();
    int n = 0;
    report_ready = 1'b0;
    exp_q.push_back(8'd1);
    pulse();
    while (!report_valid && n < 30) begin cyc(); n++; end
    total++;
    if (n !== 16) begin bad++; $display("FAIL bp_latency: got %0d, required 16", n); end
    for (int i = 0; i < 5; i++) begin
      detect = (i == 1 || i == 3);
      cyc();
      total++;
      if (report_valid !== 1'b1 || report_data !== 8'd1) begin
        bad++;
        $display("FAIL bp_hold: got valid=%0d data=%0d, required 1 1", report_valid, report_data);
      end
    end
    detect = 1'b0;
    total++;
    if (total_count !== 8'd7 || alarm !== 1'b1) begin
      bad++;
      $display("FAIL bp_count_sticky: got total=%0d alarm=%0d, required 7 1", total_count, alarm);
    end
    report_ready = 1'b1;
    detect = 1'b1;
    cyc();
    detect = 1'b0;
    total++;
    if (report_valid !== 1'b0 || total_count !== 8'd8) begin
      bad++;
      $display("FAIL bp_release: got valid=%0d total=%0d, required 0 8", report_valid, total_count);
    end
    n = 0;
    repeat (20) begin cyc(); if (report_valid) n++; end
    total++;
    if (n !== 0) begin bad++; $display("FAIL bp_no_window: got %0d valid cycles, required 0", n); end
  endtask
  task automatic test_clear();
    int n = 0;
    pulse();
    cyc();
    cyc();
    clear = 1'b1;
    detect = 1'b1;
    cyc();
    clear = 1'b0;
    detect = 1'b0;
    total++;
    if ({report_valid, alarm, report_data, total_count} !== 18'd0) begin
      bad++;
      $display("FAIL clear_outputs: got %h, required 0", {report_valid, alarm, report_data, total_count});
    end
    repeat (20) begin cyc(); if (report_valid) n++; end
    total++;
    if (n !== 0 || total_count !== 8'd0) begin
      bad++;
      $display("FAIL clear_idle: got valid_cycles=%0d total=%0d, required 0 0", n, total_count);
    end
  endtask
  task automatic test_clear_report();
    int n = 0;
    report_ready = 1'b0;
    pulse();
    while (!report_valid && n < 30) begin cyc(); n++; end
    total++;
    if (report_valid !== 1'b1) begin bad++; $display("FAIL clr_rep_wait: got %0d, required 1", report_valid); end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    total++;
    if (report_valid !== 1'b0 || report_data !== 8'd0 || total_count !== 8'd0) begin
      bad++;
      $display("FAIL clr_rep_abandon: got valid=%0d data=%0d total=%0d, required 0 0 0", report_valid, report_data, total_count);
    end
    report_ready = 1'b1;
    repeat (3) cyc();
  endtask
  task automatic test_reset_mid();
    int n = 0;
    pulse();
    repeat (4) cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    total++;
    if ({report_valid, alarm, report_data, total_count} !== 18'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got %h, required 0", {report_valid, alarm, report_data, total_count});
    end
    repeat (20) begin cyc(); if (report_valid) n++; end
    total++;
    if (n !== 0) begin bad++; $display("FAIL rst_mid_discard: got %0d valid cycles, required 0", n); end
  endtask
  task automatic test_saturate();
    report_ready = 1'b0;
    exp_q.push_back(8'd3);
    for (int i = 0; i < 300; i++) begin
      pulse();
      cyc();
      if (i == 253) begin
        total++;
        if (total_count !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d, required 254", total_count); end
      end
    end
    total++;
    if (total_count !== 8'd255) begin bad++; $display("FAIL sat_300: got %0d, required 255", total_count); end
    pulse();
    total++;
    if (total_count !== 8'd255 || report_valid !== 1'b1 || report_data !== 8'd3 || alarm !== 1'b1) begin
      bad++;
      $display("FAIL sat_hold: got total=%0d valid=%0d data=%0d alarm=%0d, required 255 1 3 1", total_count, report_valid, report_data, alarm);
    end
    report_ready = 1'b1;
    cyc();
    total++;
    if (report_valid !== 1'b0) begin bad++; $display("FAIL sat_release: got %0d, required 0", report_valid); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_thresh();
    test_backpressure();
    test_clear();
    test_clear_report();
    test_reset_mid();
    test_saturate();
    cyc();
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
